// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | pipe_ctrl_pkg: shared state encoding and constants, pipe ctrl  |
// | rev 1.0                                                         |
// +----------------------------------------------------------------+
package pipe_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_IWAIT = 2'd1,
    ST_DWAIT = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | sat_counter: W-bit up counter, synchronous clear, saturates    |
// | rev 1.0                                                         |
// +----------------------------------------------------------------+
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && !(&q_q)) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------+
// | hazard_ctrl: stall/flush/freeze sequencing for the 5-stage core|
// | rev 1.0                                                         |
// +----------------------------------------------------------------+
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             back_en,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic load_use, dwait, iwait, wait_hit, sel_branch;
  logic stall_inc, flush_inc;

  always_comb begin
    load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
               ((id_uses_rs && (ex_rd == id_rs)) || (id_uses_rt && (ex_rd == id_rt)));
    dwait    = mem_access && !dmem_ready;
    iwait    = !imem_ready;
    wait_hit = dwait || (iwait && !branch_taken);

    pc_we       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    back_en     = 1'b1;
    sel_branch  = 1'b0;

    // Priority decode; a branch seen during a freeze stays asserted and lands afterwards
    if (rst) begin
      pc_we       = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      back_en     = 1'b0;
    end else if (state_q == ST_ERR) begin
      pc_we   = 1'b0;
      ifid_en = 1'b0;
      back_en = 1'b0;
    end else if (dwait) begin
      pc_we   = 1'b0;
      ifid_en = 1'b0;
      back_en = 1'b0;
    end else if (branch_taken) begin
      sel_branch  = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_we       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end else if (iwait) begin
      pc_we      = 1'b0;
      ifid_flush = 1'b1;
    end

    mem_timeout = !rst && (state_q == ST_ERR);

    if (state_q == ST_ERR) begin
      state_d = ST_ERR;
    end else if (wait_hit && (wait_cnt_q == WAIT_LAST)) begin
      state_d = ST_ERR;
    end else if (dwait) begin
      state_d = ST_DWAIT;
    end else if (iwait && !branch_taken && !load_use) begin
      state_d = ST_IWAIT;
    end else begin
      state_d = ST_RUN;
    end

    wait_cnt_d = wait_cnt_q;
    if (state_q != ST_ERR) begin
      case (state_d)
        ST_RUN:   wait_cnt_d = '0;
        ST_IWAIT,
        ST_DWAIT: wait_cnt_d = (state_d == state_q) ? wait_cnt_q + 1'b1 : CNT_W'(1);
        default:  wait_cnt_d = wait_cnt_q;
      endcase
    end

    stall_inc = !rst && (state_q != ST_ERR) && !pc_we;
    flush_inc = !rst && sel_branch;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .inc (stall_inc),
    .clr (rst),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .inc (flush_inc),
    .clr (rst),
    .q   (flush_cnt)
  );

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage core. It owns every stall, flush and freeze decision: it drives the IF_ID enable and synchronous clear, the PC write enable, the ID/EX bubble and the back-end register enables. It detects load-use hazards, taken-branch redirects and instruction/data memory wait states. It also tracks consecutive wait cycles for a timeout trap and keeps saturating stall and flush statistics.

## Interface
- MAX_WAIT, 16: consecutive wait cycles (either memory) that trigger a timeout; legal range 2..2^CNT_W-1.
- CNT_W, 16: width of the wait counter and both statistic counters.

- clk  in  1  single clock, posedge.
- rst  in  1  reset; synchronous, active-high.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads that source.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of the instruction in EX.
- branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- imem_ready  in  1  instruction fetch completes this cycle.
- mem_access  in  1  MEM stage holds a load or store.
- dmem_ready  in  1  data access completes this cycle.
- pc_we  out  1  PC register load enable.
- ifid_en  out  1  IF_ID load enable.
- ifid_flush  out  1  IF_ID synchronous clear (ORed with rst at IF_ID).
- idex_bubble  out  1  ID/EX loads a NOP instead of ID outputs.
- back_en  out  1  enable for ID/EX, EX/MEM, MEM/WB.
- mem_timeout  out  1  sticky timeout flag.
- stall_cnt, flush_cnt  out  CNT_W each  saturating statistics.

## Operation
- States: RUN, IWAIT, DWAIT, ERR. State, wait_cnt and counters are registered; control outputs are a Mealy decode of state plus current inputs.
- load_use = ex_mem_read & ex_rd!=0 & ((id_uses_rs & ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
- dwait = mem_access & !dmem_ready. iwait = !imem_ready.
- Output decode, first match wins:
  - ERR: all enables 0, ifid_flush=0, idex_bubble=0.
  - dwait (freeze): pc_we=0, ifid_en=0, back_en=0, ifid_flush=0, idex_bubble=0.
  - branch_taken: pc_we=1, ifid_en=1, ifid_flush=1, idex_bubble=1, back_en=1.
  - load_use: pc_we=0, ifid_en=0, idex_bubble=1, back_en=1, ifid_flush=0.
  - iwait: pc_we=0, ifid_en=1, ifid_flush=1 (NOP into ID), idex_bubble=0, back_en=1.
  - else: pc_we=1, ifid_en=1, back_en=1, ifid_flush=0, idex_bubble=0.
- A branch arriving during a freeze is not lost. EX is frozen, so branch_taken stays high and is applied on the first non-freeze cycle.
- Next state:
  - ERR is absorbing until rst.
  - Otherwise go to ERR if a wait condition (dwait, or iwait with no branch) holds while wait_cnt==MAX_WAIT-1.
  - Otherwise DWAIT if dwait; IWAIT if iwait and no branch_taken and no load_use; else RUN.
- wait_cnt:
  - Increments when the next state equals the current wait state.
  - Loads 1 on entry to IWAIT/DWAIT, including a direct switch IWAIT↔DWAIT.
  - Clears on RUN.
- stall_cnt: +1 in every non-reset, non-ERR cycle with pc_we=0.
- flush_cnt: +1 in every non-reset cycle where the branch flush row is selected.
- Both statistic counters saturate at all-ones.
- mem_timeout = (state==ERR).

## Timing
- Control outputs respond combinationally in the same cycle; there is no added pipeline latency.
- Load-use costs exactly one bubble: the load moves to MEM next cycle and the condition clears.
- Timeout: with MAX_WAIT consecutive wait cycles, ERR is entered at the rising edge that ends wait cycle MAX_WAIT. mem_timeout is high from the following cycle.
- While rst=1, outputs are forced to pc_we=0, ifid_en=1, ifid_flush=1, idex_bubble=1, back_en=0, mem_timeout=0.
- At the reset edge: state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0. Reset takes effect from any state, mid-wait included.

## Structure
- Shared package/include pipe_ctrl_pkg holds the state encoding (RUN=0, IWAIT=1, DWAIT=2, ERR=3) and the register-zero constant.
- One sub-module is natural: sat_counter (parameter W; ports inc, clr, q), instantiated for stall_cnt and flush_cnt.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5, id_uses_rs=1 for 1 cycle -> pc_we=0, ifid_en=0, idex_bubble=1, back_en=1; stall_cnt 0→1. Same stimulus with ex_rd=0 -> no stall.
- Simultaneous branch_taken=1 and load_use -> flush row: ifid_flush=1, idex_bubble=1, pc_we=1; flush_cnt 0→1; stall_cnt unchanged.
- mem_access=1, dmem_ready=0 for 3 cycles with branch_taken=1 held -> back_en=0 and pc_we=0 for 3 cycles, flush on 4th cycle; stall_cnt=3, flush_cnt=1.
- MAX_WAIT=4, imem_ready=0 held -> ifid_flush=1 for cycles 1–4, state ERR after edge 4, mem_timeout=1, all enables 0 until rst.
- IWAIT 2 cycles, then dwait 2 cycles, then ready -> wait_cnt reloads to 1 at switch; no timeout with MAX_WAIT=4.
- rst asserted during DWAIT with counters nonzero -> next cycle state RUN, counters 0, mem_timeout=0.
